// File: rtl/mmu_pkg.sv
// mmu_pkg: shared helpers for the MMU datapath packers.
package mmu_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int unsigned sanitise_ratio(input int unsigned r, input int unsigned p_max);
    return (r == 0 || r > p_max) ? p_max : r;
  endfunction
  function automatic logic lane_used(input int unsigned k, input int unsigned n);
    return k < n;
  endfunction
endpackage

// File: rtl/s2p_lane_acc.sv
// s2p_lane_acc: lane accumulator with shift (rev) or indexed (fwd) beat insertion.
module s2p_lane_acc
  import mmu_pkg::*;
#(
  parameter int P_MAX   = 4,
  parameter int DATA_IN = 8,
  parameter int CW      = clog2(P_MAX + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              accept,
  input  logic                              rev,
  input  logic                              clear,
  input  logic [CW-1:0]                     ratio_eff,
  input  logic [DATA_IN-1:0]                data_in,
  output logic [CW-1:0]                     cnt,
  output logic                              last,
  output logic [P_MAX-1:0][DATA_IN-1:0]     word,
  output logic [CW-1:0]                     word_cnt
);
  logic [P_MAX-1:0][DATA_IN-1:0] acc_q, acc_d, fwd, ins, src;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done;
  assign cnt = cnt_q;
  always_comb begin
    for (int k = 0; k < P_MAX; k++) fwd[k] = (CW'(k) == cnt_q) ? data_in : acc_q[k];
    ins = rev ? {acc_q[P_MAX-2:0], data_in} : fwd;
    last = cnt_q == ratio_eff - 1'b1;
    done = accept & last;
    word_cnt = accept ? ratio_eff : cnt_q;
    src = accept ? ins : acc_q;
    // Lanes past the word length are forced to zero so partial words stay clean.
    for (int k = 0; k < P_MAX; k++) word[k] = lane_used(unsigned'(k), 32'(word_cnt)) ? src[k] : '0;
    acc_d = (done | clear) ? '0 : accept ? ins : acc_q;
    cnt_d = (done | clear) ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/s2p_gen.sv
// s2p_gen: run-time ratio serial-to-parallel packer with valid/ready output and flush.
module s2p_gen
  import mmu_pkg::*;
#(
  parameter int P_MAX   = 4,
  parameter int DATA_IN = 8,
  parameter int CW      = clog2(P_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_IN-1:0]         data_in,
  input  logic [CW-1:0]              ratio,
  input  logic                       rev,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [P_MAX*DATA_IN-1:0]   data_out,
  output logic [CW-1:0]              out_cnt
);
  logic [CW-1:0] ratio_l_q, ratio_l_d, out_cnt_q, out_cnt_d;
  logic rev_l_q, rev_l_d, flush_pend_q, flush_pend_d, out_valid_q, out_valid_d;
  logic [P_MAX*DATA_IN-1:0] data_out_q, data_out_d;
  logic [CW-1:0] cnt, ratio_in, ratio_eff, word_cnt;
  logic [P_MAX-1:0][DATA_IN-1:0] word;
  logic rev_eff, slot_free, accept, last, do_flush, load;
  s2p_lane_acc #(.P_MAX(P_MAX), .DATA_IN(DATA_IN), .CW(CW)) u_acc (
    .clk(clk), .rst(rst), .accept(accept), .rev(rev_eff), .clear(do_flush),
    .ratio_eff(ratio_eff), .data_in(data_in), .cnt(cnt), .last(last),
    .word(word), .word_cnt(word_cnt)
  );
  always_comb begin
    ratio_in = CW'(sanitise_ratio(32'(ratio), P_MAX));
    ratio_eff = (cnt != '0) ? ratio_l_q : ratio_in;
    rev_eff = (cnt != '0) ? rev_l_q : rev;
    slot_free = !out_valid_q | out_ready;
    // Mid-word beats never need the output slot; only the completing beat does.
    in_ready = !flush_pend_q & ((({1'b0, cnt} + 1'b1) < {1'b0, ratio_eff}) | slot_free);
    accept = in_valid & in_ready;
    do_flush = flush_pend_q & slot_free;
    load = (accept & last) | (do_flush & (cnt != '0));
    ratio_l_d = (accept & (cnt == '0)) ? ratio_in : ratio_l_q;
    rev_l_d = (accept & (cnt == '0)) ? rev : rev_l_q;
    flush_pend_d = do_flush ? 1'b0 : (flush_pend_q | flush);
    out_valid_d = load | (out_valid_q & !out_ready);
    data_out_d = load ? word : data_out_q;
    out_cnt_d = load ? word_cnt : out_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_l_q <= '0;
      rev_l_q <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q <= '0;
      out_cnt_q <= '0;
    end else begin
      ratio_l_q <= ratio_l_d;
      rev_l_q <= rev_l_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q <= out_valid_d;
      data_out_q <= data_out_d;
      out_cnt_q <= out_cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign data_out = data_out_q;
  assign out_cnt = out_cnt_q;
endmodule

// File: tb/tb_s2p_gen.sv
// tb_s2p_gen: directed-vector bench for s2p_gen with P_MAX=4, DATA_IN=8.
module tb_s2p_gen;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, rev = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [7:0] data_in = '0;
  logic [2:0] ratio = 3'd4;
  logic in_ready, out_valid;
  logic [31:0] data_out;
  logic [2:0] out_cnt;
  int n_chk = 0, n_fail = 0, gaps = 0;

  s2p_gen #(.P_MAX(4), .DATA_IN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .ratio(ratio), .rev(rev), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    data_in = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", data_out, 32'h0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    // rev=1, ratio=4
    rev = 1'b1;
    beat(8'h11); beat(8'h22); beat(8'h33);
    check("a_pre_valid", 32'(out_valid), 32'd0);
    beat(8'h44);
    check("a_valid", 32'(out_valid), 32'd1);
    check("a_data", data_out, 32'h11223344);
    check("a_cnt", 32'(out_cnt), 32'd4);
    step();
    check("a_drain", 32'(out_valid), 32'd0);
    // rev=0 back-to-back words
    rev = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (!in_ready) gaps++;
        beat(8'(8'h11 * (b + 1)));
        if (w == 1 && b == 0) check("b_w1_accepted", 32'(out_valid), 32'd0);
      end
      check("b_valid", 32'(out_valid), 32'd1);
      check("b_data", data_out, 32'h44332211);
    end
    check("b_gaps", 32'(gaps), 32'd0);
    step();
    // ratio=3, then ratio=0 with a mid-word ratio change ignored
    ratio = 3'd3;
    beat(8'hA1); beat(8'hA2); beat(8'hA3);
    check("c3_data", data_out, 32'h00A3A2A1);
    check("c3_cnt", 32'(out_cnt), 32'd3);
    ratio = 3'd0;
    beat(8'h01);
    ratio = 3'd2;
    beat(8'h02); beat(8'h03);
    check("c0_pre_valid", 32'(out_valid), 32'd0);
    beat(8'h04);
    check("c0_data", data_out, 32'h04030201);
    check("c0_cnt", 32'(out_cnt), 32'd4);
    ratio = 3'd1;
    beat(8'h5A);
    check("r1_data", data_out, 32'h0000005A);
    check("r1_cnt", 32'(out_cnt), 32'd1);
    beat(8'h5B);
    check("r1_valid", 32'(out_valid), 32'd1);
    check("r1_data2", data_out, 32'h0000005B);
    ratio = 3'd4;
    step();
    // backpressure
    out_ready = 1'b0;
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    check("d_w1_data", data_out, 32'h04030201);
    beat(8'h05); beat(8'h06); beat(8'h07);
    in_valid = 1'b1;
    data_in = 8'h08;
    #1;
    check("d_stall_ready", 32'(in_ready), 32'd0);
    step();
    check("d_hold_valid", 32'(out_valid), 32'd1);
    check("d_hold_data", data_out, 32'h04030201);
    out_ready = 1'b1;
    #1;
    check("d_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("d_w2_valid", 32'(out_valid), 32'd1);
    check("d_w2_data", data_out, 32'h08070605);
    step();
    check("d_drain", 32'(out_valid), 32'd0);
    // flush partial word, rev=1
    rev = 1'b1;
    beat(8'hB1); beat(8'hB2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("e_pend_ready", 32'(in_ready), 32'd0);
    check("e_pend_valid", 32'(out_valid), 32'd0);
    step();
    check("e_valid", 32'(out_valid), 32'd1);
    check("e_data", data_out, 32'h0000B1B2);
    check("e_cnt", 32'(out_cnt), 32'd2);
    check("e_ready", 32'(in_ready), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("e_empty_valid", 32'(out_valid), 32'd0);
    check("e_empty_ready", 32'(in_ready), 32'd1);
    // beat accepted with the flush pulse is included
    rev = 1'b0;
    beat(8'hC1);
    flush = 1'b1;
    beat(8'hC2);
    flush = 1'b0;
    step();
    check("e2_data", data_out, 32'h0000C2C1);
    check("e2_cnt", 32'(out_cnt), 32'd2);
    step();
    // flush while the output slot is stalled
    out_ready = 1'b0;
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    beat(8'hD1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("f_ready", 32'(in_ready), 32'd0);
    step();
    check("f_hold_data", data_out, 32'h04030201);
    out_ready = 1'b1;
    step();
    check("f_valid", 32'(out_valid), 32'd1);
    check("f_data", data_out, 32'h000000D1);
    check("f_cnt", 32'(out_cnt), 32'd1);
    step();
    check("f_drain", 32'(out_valid), 32'd0);
    // async reset mid-word with a stalled output
    out_ready = 1'b0;
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    beat(8'hE1); beat(8'hE2);
    rst = 1'b1;
    #1;
    check("g_valid", 32'(out_valid), 32'd0);
    check("g_data", data_out, 32'h0);
    check("g_cnt", 32'(out_cnt), 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("g_no_word", 32'(out_valid), 32'd0);
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    check("g_clean_data", data_out, 32'h04030201);
    check("g_clean_cnt", 32'(out_cnt), 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/s2p_gen.md
Name: s2p_gen

Overview:
Parametrised serial-to-parallel packer for the MMU datapath. It gathers DATA_IN-bit beats into words of up to P_MAX lanes. The packing ratio and lane order are chosen at run time, the output uses a valid/ready handshake with backpressure, and a flush request emits partial words. It replaces fixed-ratio shift packers wherever producer and consumer rates differ or tensor tails are not a multiple of the word size.

Parameters:
P_MAX, 4, maximum lanes per output word (>=2)
DATA_IN, 8, bits per input beat
CW, clog2(P_MAX+1), width of ratio and lane-count fields (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat offered
in_ready  out  1  input beat accepted when in_valid&in_ready
data_in  in  DATA_IN  input beat
ratio  in  CW  beats per word; 0 or >P_MAX means P_MAX
rev  in  1  1: newest beat in lane 0 (shift order); 0: first beat in lane 0
flush  in  1  one-cycle request to emit the partial word
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts when out_valid&out_ready
data_out  out  P_MAX*DATA_IN  packed word; lane k = bits [(k+1)*DATA_IN-1 : k*DATA_IN]
out_cnt  out  CW  number of meaningful lanes in data_out (1..P_MAX)

Behaviour:
- Reset (async, immediate): acc, cnt, ratio_l, rev_l, flush_pend, data_out, out_cnt all 0; out_valid=0; in_ready=1 once rst deasserts.
- Storage: accumulator acc (P_MAX lanes) plus counter cnt (0..ratio_l-1), and an output register (data_out/out_cnt/out_valid).
- ratio and rev are latched into ratio_l/rev_l on the first accepted beat of a word (cnt==0). Changes mid-word are ignored until the next word.
- slot_free = !out_valid | out_ready.
- in_ready = !flush_pend & ((cnt+1 < ratio_eff) | slot_free).
  - ratio_eff = ratio_l when cnt>0, otherwise the sanitised ratio input.
  - Combinational: in_ready does not depend on in_valid.
- Beat accept, rev=1:
  - acc lane 0 <= data_in; lane k <= lane k-1.
  - After n beats, the oldest beat is in lane n-1.
- Beat accept, rev=0: acc lane cnt <= data_in.
- Word complete (beat accepted with cnt==ratio_eff-1):
  - Same edge: data_out <= acc with the new beat applied, lanes >= ratio_eff forced to 0; out_cnt <= ratio_eff; out_valid <= 1.
  - acc and cnt cleared on the same edge.
  - Latency: out_valid rises the cycle after the last beat is accepted.
  - Back-to-back words at full throughput (one beat per cycle) when out_ready=1.
- Output handshake: data_out/out_cnt stay stable while out_valid & !out_ready. out_valid falls after acceptance unless a new word loads on the same edge.
- Flush:
  - A flush pulse sets flush_pend. While flush_pend=1, in_ready=0.
  - A beat accepted in the same cycle as the flush pulse is included before flushing.
  - On the first cycle with flush_pend & slot_free:
    - cnt>0: emit acc as a partial word (out_cnt=cnt, unused lanes 0) and clear acc/cnt.
    - cnt==0: emit nothing.
    - Either case: flush_pend clears.
- A flush pulse while flush_pend is already set is absorbed (no second flush).
- ratio_eff==1: every beat is a full word; data_out lane 0 = beat.
- Reset mid-word or mid-handshake: everything is discarded, with no partial output.

Decomposition:
- Shared package mmu_pkg: clog2 function, lane slice helper, sanitise-ratio function.
- One sub-module, s2p_lane_acc: holds acc/cnt and the rev/fwd insertion logic.
- The top level holds the latches, flush_pend, the output register and the handshake.

Test Plan:
- P_MAX=4, ratio=4, rev=1, beats 0x11,0x22,0x33,0x44, out_ready=1 -> next cycle out_valid=1, data_out=0x11223344, out_cnt=4.
- Same beats with rev=0 -> data_out=0x44332211. Repeat continuously: one word every 4 cycles with no in_ready gaps.
- ratio=3, rev=0, beats A1,A2,A3 -> data_out=0x00A3A2A1, out_cnt=3. ratio=0 -> behaves as 4.
- out_ready=0 after the first word completes, keep streaming:
  - in_ready drops on the 4th beat of the second word; word 1 stays stable.
  - Raising out_ready for 1 cycle -> word 1 accepted and word 2 loads on the same edge.
- 2 beats B1,B2 (rev=1) then flush -> out_cnt=2, data_out=0x0000B1B2. Flush with cnt==0 -> no out_valid.
- Flush asserted while out_valid&!out_ready holds -> in_ready=0 until the slot frees, then the partial word is emitted. Assert rst mid-word -> all outputs 0 immediately and no word emitted.
